mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Requester-side controller that drives the single-port 4 KB data memory, with 1024 words, combinational read and write on the clock edge when write-enable is high. It accepts load/store requests from the datapath with byte, halfword or word size. It performs sub-word stores by read-modify-write, and sign- or zero-extends sub-word loads. It also flags misaligned accesses. It sits between the CPU memory stage and the data memory, and is the only agent allowed to drive the memory's address, write-data and write-enable.

Parameters:
ADDR_W, 10, width of the data-memory word address; byte address bits [ADDR_W+1:2] are forwarded to memory.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  1  request strobe; sampled only when ready=1
wr  input  1  1 = store, 0 = load
size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word
sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  input  32  byte address
wdata  input  32  store data; the low byte or low half is used for sub-word stores
ready  output  1  1 when idle and able to accept req
done  output  1  one-cycle pulse marking request completion
err  output  1  valid with done; 1 = misaligned, access suppressed
rdata  output  32  load result; held until the next load completes
dm_addr  output  ADDR_W  word address to memory
dm_din  output  32  write data to memory
dm_we  output  1  memory write enable
dm_dout  input  32  memory read data (combinational from dm_addr)

Behaviour:
- Byte-lane order is little-endian.
  - Byte k of a word occupies bits [8k+7:8k], where k = addr[1:0].
  - Halfword at addr[1]=0 occupies [15:0]; at addr[1]=1 it occupies [31:16].
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- Reset values: state=IDLE, ready=1, done=0, err=0, rdata=0, dm_addr=0, dm_din=0, dm_we=0.
- IDLE (ready=1):
  - On req=1, latch wr, size, sext, wdata, and addr[ADDR_W+1:0].
  - dm_addr follows the latched word address from the next cycle onward.
  - Misaligned means size=1 with addr[0]=1, or size=2/3 with addr[1:0]≠0. Misaligned → DONE with err=1; no memory read or write occurs.
  - Aligned load → LOAD.
  - Aligned word store → WRITE with dm_din = wdata.
  - Aligned byte or half store → RMW_RD.
- LOAD:
  - Extract the selected lane from dm_dout and extend it per sext; word loads ignore sext.
  - Register the result into rdata, then → DONE.
- RMW_RD: register dm_din = dm_dout with the selected lane replaced by wdata[7:0] or wdata[15:0], then → WRITE.
- WRITE: dm_we=1 for exactly this cycle, with dm_din stable, then → DONE.
- DONE:
  - done=1 and err as latched, for one cycle, then → IDLE.
  - err clears to 0 when done deasserts.
- ready=1 only in IDLE. req in any other state is ignored and not queued. A new request is accepted at the earliest in the cycle after DONE.
- Latency from the req-accept edge to done high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - misaligned: 1 cycle
- dm_we is asserted only in WRITE, and only when rst=0. A reset in the WRITE cycle suppresses that write.
- Reset mid-operation (any state): the next state is IDLE with all outputs at reset values. The aborted request produces no done and no partial write.
- rdata changes only on load completion. Stores and errors leave it unchanged.
- Address bits above ADDR_W+1 are ignored; there is no range error.

Test Plan:
1. Preload word 0x004 (byte 0x010) = 0x8899AABB; word load at addr 0x010 → done 2 cycles after accept, rdata = 0x8899AABB, err = 0, dm_we never high.
2. Byte load, sext=1, addr 0x013 → rdata = 0xFFFFFF88. Byte load, sext=0, addr 0x011 → rdata = 0x000000AA. Half load, sext=1, addr 0x012 → rdata = 0xFFFF8899.
3. Byte store at 0x012, wdata = 0x12345677 → single dm_we pulse in cycle 2 with dm_din = 0x8877AABB, done in cycle 3. A word load at 0x010 then returns 0x8877AABB.
4. Half store at 0x011 (misaligned) → done and err = 1 in cycle 1, dm_we never asserted, memory word unchanged, rdata unchanged.
5. rst asserted during the WRITE cycle of a half store to 0x010 → no write, so the word stays 0x8899AABB. Next cycle: ready = 1, done = 0, dm_we = 0.
6. req held high continuously for word store 0x020 = 0xDEADBEEF, then word load 0x020 → the second request is accepted only in the IDLE cycle after the first done. Requests during busy are ignored. The load returns 0xDEADBEEF.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Requester-side data-memory controller: byte/half/word loads and stores,
// with read-modify-write for sub-word stores and misalignment flagging.

module mem_lane_merge (
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  input  logic       sel,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module mem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

  typedef struct packed {
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  boff;
    logic [15:0] wlo;
  } req_t;

  state_t state;
  req_t   r;
  logic   we_r;
  logic   mis;
  logic   unused_hi;

  logic [7:0]                      ld_b;
  logic [15:0]                     ld_h;
  logic [31:0]                     ld_val;
  logic [NUM_LANES-1:0][7:0]       old_w;
  logic [NUM_LANES-1:0][7:0]       lane_new;
  logic [NUM_LANES-1:0][7:0]       merged;
  logic [NUM_LANES-1:0]            lane_sel;

  assign unused_hi = &{1'b0, addr[31:ADDR_W+2]};
  assign mis = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);

  // A reset arriving during WRITE must block that cycle's memory write.
  assign dm_we = we_r & ~rst;

  always_comb begin
    ld_b = 8'h00;
    case (r.boff)
      2'd0: ld_b = dm_dout[7:0];
      2'd1: ld_b = dm_dout[15:8];
      2'd2: ld_b = dm_dout[23:16];
      default: ld_b = dm_dout[31:24];
    endcase
    ld_h = r.boff[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (r.size)
      2'd0:    ld_val = {{24{r.sext & ld_b[7]}}, ld_b};
      2'd1:    ld_val = {{16{r.sext & ld_h[15]}}, ld_h};
      default: ld_val = dm_dout;
    endcase
  end

  assign old_w = dm_dout;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      localparam logic [1:0] K = 2'(k);
      assign lane_sel[k] = (r.size == 2'd0) ? (r.boff == K) : (r.boff[1] == K[1]);
      assign lane_new[k] = (r.size == 2'd0 || !K[0]) ? r.wlo[7:0] : r.wlo[15:8];
      mem_lane_merge u_merge (
        .old_b (old_w[k]),
        .new_b (lane_new[k]),
        .sel   (lane_sel[k]),
        .out_b (merged[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      dm_addr <= '0;
      dm_din  <= '0;
      we_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          r       <= '{size: size, sext: sext, boff: addr[1:0], wlo: wdata[15:0]};
          dm_addr <= addr[ADDR_W+1:2];
          ready   <= 1'b0;
          if (mis) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (!wr) begin
            state <= LOAD;
          end else if (size[1]) begin
            dm_din <= wdata;
            we_r   <= 1'b1;
            state  <= WRITE;
          end else begin
            state <= RMW_RD;
          end
        end
        LOAD: begin
          rdata <= ld_val;
          done  <= 1'b1;
          state <= DONE;
        end
        RMW_RD: begin
          dm_din <= merged;
          we_r   <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          we_r  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
